// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: drives the PC write enable and PC mux select, and runs
// the multi-cycle interrupt entry (push PC halves, jump to vector) and return
// (pop PC halves, resume) sequences. The global interrupt enable lives here.
module fetch_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       ret_req,
  input  logic       is_rti,
  input  logic       int_req,
  output logic       pc_enable,
  output logic [1:0] pc_selection,
  output logic       pop_pc_high_sig,
  output logic       pop_pc_low_sig,
  output logic       push_pc_req,
  output logic       push_half,
  output logic       flush,
  output logic       int_ack,
  output logic       int_en,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    StBoot   = 3'd0,
    StRun    = 3'd1,
    StPushL  = 3'd2,
    StPushH  = 3'd3,
    StIntJmp = 3'd4,
    StPopH   = 3'd5,
    StPopL   = 3'd6,
    StResume = 3'd7
  } state_e;

  localparam logic [1:0] SelNext = 2'b00;
  localparam logic [1:0] SelBranch = 2'b01;
  localparam logic [1:0] SelIntVec = 2'b10;
  localparam logic [1:0] SelBootVec = 2'b11;

  state_e state_q;
  logic   int_en_q;
  logic   rti_pend_q;

  logic   int_take;
  assign int_take = int_req && int_en_q;

  // State, interrupt enable and pending-RTI flag; events are only honoured in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      int_en_q   <= 1'b1;
      rti_pend_q <= 1'b0;
    end else begin
      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun: begin
          if (branch_taken) begin
            state_q <= StRun;
          end else if (ret_req) begin
            state_q    <= StPopH;
            rti_pend_q <= is_rti;
          end else if (int_take) begin
            state_q <= StPushL;
          end
        end
        StPushL: state_q <= StPushH;
        StPushH: state_q <= StIntJmp;
        StIntJmp: begin
          state_q  <= StRun;
          int_en_q <= 1'b0;
        end
        StPopH: state_q <= StPopL;
        StPopL: state_q <= StResume;
        StResume: begin
          state_q <= StRun;
          // Only RTI re-enables interrupts; a plain RET leaves int_en as it was.
          if (rti_pend_q) begin
            int_en_q   <= 1'b1;
            rti_pend_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Output decode from the registered state plus the RUN-state input priority.
  always_comb begin
    pc_enable       = 1'b0;
    pc_selection    = SelNext;
    pop_pc_high_sig = 1'b0;
    pop_pc_low_sig  = 1'b0;
    push_pc_req     = 1'b0;
    push_half       = 1'b0;
    flush           = 1'b0;
    int_ack         = 1'b0;
    unique case (state_q)
      StBoot: begin
        pc_enable    = 1'b1;
        pc_selection = SelBootVec;
      end
      StRun: begin
        if (branch_taken) begin
          pc_enable    = 1'b1;
          pc_selection = SelBranch;
          flush        = 1'b1;
        end else if (ret_req || int_take) begin
          flush = 1'b1;
        end else if (!stall) begin
          pc_enable = 1'b1;
        end
      end
      StPushL: push_pc_req = 1'b1;
      StPushH: begin
        push_pc_req = 1'b1;
        push_half   = 1'b1;
      end
      StIntJmp: begin
        pc_enable    = 1'b1;
        pc_selection = SelIntVec;
        int_ack      = 1'b1;
      end
      StPopH: pop_pc_high_sig = 1'b1;
      StPopL: pop_pc_low_sig = 1'b1;
      StResume: pc_selection = SelNext;
    endcase
  end

  assign int_en    = int_en_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a driver applies directed and random
// stimulus and pushes the expected outputs for each cycle; a monitor on the
// falling edge pops and compares. The reference model treats each accepted
// interrupt/return as a canned script of future cycles.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0, branch_taken = 1'b0, ret_req = 1'b0, is_rti = 1'b0;
  logic       int_req = 1'b0;
  logic       pc_enable;
  logic [1:0] pc_selection;
  logic       pop_pc_high_sig, pop_pc_low_sig, push_pc_req, push_half, flush, int_ack;
  logic       int_en;
  logic [2:0] state_dbg;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .ret_req        (ret_req),
    .is_rti         (is_rti),
    .int_req        (int_req),
    .pc_enable      (pc_enable),
    .pc_selection   (pc_selection),
    .pop_pc_high_sig(pop_pc_high_sig),
    .pop_pc_low_sig (pop_pc_low_sig),
    .push_pc_req    (push_pc_req),
    .push_half      (push_half),
    .flush          (flush),
    .int_ack        (int_ack),
    .int_en         (int_en),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  // {en, sel[1:0], flush, push, half, poph, popl, ack, ie, st[2:0]}
  typedef logic [12:0] vec_t;
  // Side effect on the interrupt enable once a scripted cycle completes.
  typedef enum int {EffNone, EffClear, EffSet} eff_e;
  typedef struct {
    vec_t v;
    eff_e eff;
  } item_t;

  vec_t  exp_q[$];
  item_t script[$];
  logic  ie_m = 1'b1;
  logic  last_ack = 1'b0;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;

  function automatic vec_t mk(input logic en, input logic [1:0] sel, input logic fl,
                              input logic pu, input logic hf, input logic ph, input logic pl,
                              input logic ak, input logic [2:0] st);
    return {en, sel, fl, pu, hf, ph, pl, ak, 1'b0, st};
  endfunction

  // One clock of stimulus; the model decides what this cycle must show.
  task automatic step(input logic s, input logic b, input logic r, input logic ti,
                      input logic iq, input logic rs);
    vec_t  e;
    item_t it;
    @(posedge clk);
    #1;
    stall = s; branch_taken = b; ret_req = r; is_rti = ti; int_req = iq; rst = rs;
    if (rs) begin
      script.delete();
      script.push_back('{mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 3'd0), EffNone});
      ie_m = 1'b1;
      e = mk(1, 2'b11, 0, 0, 0, 0, 0, 0, 3'd0);
      e[3] = 1'b1;
    end else if (script.size() != 0) begin
      it = script.pop_front();
      e = it.v;
      e[3] = ie_m;
      if (it.eff == EffClear) ie_m = 1'b0;
      if (it.eff == EffSet) ie_m = 1'b1;
    end else begin
      // Running: highest-priority event wins; anything deferred stays on its input.
      if (b) begin
        e = mk(1, 2'b01, 1, 0, 0, 0, 0, 0, 3'd1);
      end else if (r) begin
        e = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 3'd1);
        script.push_back('{mk(0, 2'b00, 0, 0, 0, 1, 0, 0, 3'd5), EffNone});
        script.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 3'd6), EffNone});
        script.push_back('{mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'd7), ti ? EffSet : EffNone});
      end else if (iq && ie_m) begin
        e = mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 3'd1);
        script.push_back('{mk(0, 2'b00, 0, 1, 0, 0, 0, 0, 3'd2), EffNone});
        script.push_back('{mk(0, 2'b00, 0, 1, 1, 0, 0, 0, 3'd3), EffNone});
        script.push_back('{mk(1, 2'b10, 0, 0, 0, 0, 0, 1, 3'd4), EffClear});
      end else if (s) begin
        e = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 3'd1);
      end else begin
        e = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 3'd1);
      end
      e[3] = ie_m;
    end
    last_ack = e[4];
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs mid-cycle against the oldest expectation.
  initial begin
    vec_t act, e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        act = {pc_enable, pc_selection, flush, push_pc_req, push_half, pop_pc_high_sig,
               pop_pc_low_sig, int_ack, int_en, state_dbg};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cycle %0d outputs {en,sel,flush,push,half,poph,popl,ack,ie,st}: got %b required %b",
                   cyc, act, e);
        end
        cyc++;
      end
    end
  end

  initial begin
    logic irq;
    // Reset held, then released with no events.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    // Stall for three cycles with a branch on the second.
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Interrupt entry, then the request stays held with interrupts masked.
    repeat (7) step(0, 0, 0, 0, 1, 0);
    // RTI with the interrupt still pending: return then immediate re-entry.
    step(0, 0, 1, 1, 1, 0);
    repeat (8) step(0, 0, 0, 0, 1, 0);
    // RTI with no request to re-enable, then RET and interrupt together.
    step(0, 0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    repeat (7) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // Branch together with RET and interrupt: branch only.
    step(0, 1, 1, 1, 1, 0);
    // Reset during PUSH_H aborts the entry.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 0, 0, 1, 0);
    // Random traffic; the interrupt source holds its request until acknowledged.
    irq = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!irq && $urandom_range(0, 15) == 0) irq = 1'b1;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)), irq,
           $urandom_range(0, 199) == 0);
      if (last_ack && $urandom_range(0, 1) == 0) irq = 1'b0;
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameters: none; the PC source encodings are fixed as 00 next, 01 branch/call, 10 interrupt vector, 11 first-instruction vector.
REQ-002 clk  in  1  single system clock; all state updates on posedge clk.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 stall  in  1  hazard freeze request from the hazard unit.
REQ-005 branch_taken  in  1  resolved branch/call/jump; target is supplied to the PC mux separately.
REQ-006 ret_req  in  1  decoded RET or RTI; single-cycle pulse.
REQ-007 is_rti  in  1  qualifies ret_req as RTI; sampled with ret_req.
REQ-008 int_req  in  1  external interrupt, level, held by the source until int_ack.
REQ-009 pc_enable  out  1  PC register write enable.
REQ-010 pc_selection  out  2  PC mux source select.
REQ-011 pop_pc_high_sig, pop_pc_low_sig  out  1 each  load PC[31:16] / PC[15:0] from popped stack data.
REQ-012 push_pc_req  out  1  request the stack unit to push a PC half.
REQ-013 push_half  out  1  selects the pushed half: 0 = PC[15:0], 1 = PC[31:16].
REQ-014 flush  out  1  invalidate the fetched instruction / IF-ID register.
REQ-015 int_ack  out  1  one-cycle acknowledge to the interrupt source.
REQ-016 int_en  out  1  global interrupt-enable flag.
REQ-017 state_dbg  out  3  current state encoding.

Function
REQ-018 The FSM SHALL use these states and encodings: BOOT=0, RUN=1, PUSH_L=2, PUSH_H=3, INT_JMP=4, POP_H=5, POP_L=6, RESUME=7.
REQ-019 The block SHALL produce all outputs as Moore/registered-state decodes plus the RUN-state input decode defined below; no output SHALL depend on another output.
REQ-020 BOOT: pc_enable=1, pc_selection=11; the next state SHALL be RUN unconditionally.
REQ-021 RUN inputs SHALL be handled in this priority order: branch_taken > ret_req > (int_req & int_en) > stall > normal.
REQ-022 RUN, branch_taken: pc_enable=1, pc_selection=01, flush=1; the state SHALL stay RUN.
REQ-023 RUN, ret_req: pc_enable=0, flush=1, next=POP_H; is_rti SHALL be latched into rti_pend.
REQ-024 RUN, int_req & int_en: pc_enable=0, flush=1, next=PUSH_L.
REQ-025 RUN, stall only: pc_enable=0 and flush=0; the PC SHALL hold.
REQ-026 RUN, no event: pc_enable=1, pc_selection=00.
REQ-027 PUSH_L: push_pc_req=1, push_half=0, pc_enable=0, next=PUSH_H; PUSH_H: push_pc_req=1, push_half=1, pc_enable=0, next=INT_JMP.
REQ-028 INT_JMP: pc_enable=1, pc_selection=10, int_ack=1, int_en cleared at the clock edge, next=RUN.
REQ-029 POP_H: pop_pc_high_sig=1, pc_enable=0, next=POP_L; POP_L: pop_pc_low_sig=1, pc_enable=0, next=RESUME.
REQ-030 RESUME: pc_enable=0, pc_selection=00, next=RUN; if rti_pend=1, int_en SHALL be set and rti_pend cleared at this edge.
REQ-031 Interrupt latency SHALL be exactly 3 cycles from RUN acceptance to PC=vector; return latency SHALL be 3 cycles from ret_req to RUN.
REQ-032 int_req, ret_req and branch_taken SHALL be ignored outside RUN; int_req stays pending because it is level-held.
REQ-033 stall SHALL NOT pause the PUSH/POP/INT_JMP/RESUME sequences.
REQ-034 In all non-RUN states, flush=0 except as stated, and unasserted outputs SHALL be 0.

Reset
REQ-035 While rst=1, the block SHALL hold state=BOOT, int_en=1, rti_pend=0, and drive all outputs per BOOT (pc_enable=1, pc_selection=11, all others 0).
REQ-036 Reset assertion mid-sequence (e.g. PUSH_H or POP_L) SHALL abort immediately to BOOT with no further push/pop strobes.

Verification
REQ-037 Reset release, no events -> cycle 0 BOOT sel=11 en=1; then RUN with sel=00 en=1 every cycle; state_dbg 0 then 1.
REQ-038 In RUN, stall=1 for 3 cycles with branch_taken=1 on the 2nd -> en=0, en=1/sel=01/flush=1, en=0, then resume sel=00.
REQ-039 int_req=1 in RUN -> PUSH_L (push, half=0), PUSH_H (push, half=1), INT_JMP (sel=10, en=1, int_ack=1), then int_en=0; holding int_req afterwards SHALL NOT re-enter PUSH_L.
REQ-040 ret_req=1 with is_rti=1 after an interrupt -> flush, POP_H (pop_pc_high_sig=1), POP_L (pop_pc_low_sig=1), RESUME, int_en=1; a pending int_req is then taken on the next RUN cycle.
REQ-041 ret_req and int_req asserted together in RUN -> POP_H path taken and interrupt deferred until back in RUN; branch_taken together with both -> branch only.
REQ-042 rst pulsed during PUSH_H -> asynchronous return to BOOT; push_pc_req=0, int_ack never asserted, int_en=1.
